// File: rtl/position_judge_pipe.sv
// Pipelined scan-point judge: tests each pixel against N_BLOCKS rectangles and one square,
// with frame-synchronous double-buffered geometry and a per-frame collision accumulator.
module position_judge_pipe #(
    parameter int unsigned N_BLOCKS = 4,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned SIZE_W   = 8,
    parameter int unsigned IDX_W    = 2
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        FRAME_START,
    input  logic                        PIX_VALID,
    input  logic [COORD_W-1:0]          X,
    input  logic [COORD_W-1:0]          Y,
    input  logic [N_BLOCKS*COORD_W-1:0] BLOCK_X,
    input  logic [N_BLOCKS*COORD_W-1:0] BLOCK_Y,
    input  logic [N_BLOCKS*SIZE_W-1:0]  BLOCK_W,
    input  logic [N_BLOCKS*SIZE_W-1:0]  BLOCK_H,
    input  logic [COORD_W-1:0]          SQUARE_X,
    input  logic [COORD_W-1:0]          SQUARE_Y,
    input  logic [SIZE_W-1:0]           SQUARE_SIZE,
    input  logic                        GEOM_LOAD,
    output logic                        GEOM_BUSY,
    output logic                        OUT_VALID,
    output logic [N_BLOCKS-1:0]         IN_BLOCK,
    output logic                        IN_SQUARE,
    output logic                        IS_EMPTY,
    output logic [IDX_W-1:0]            HIT_INDEX,
    output logic                        FRAME_DONE,
    output logic                        COLLIDE,
    output logic [N_BLOCKS-1:0]         COLLIDE_MASK
);
    localparam int unsigned EXT_W = COORD_W + 1;
    localparam int NB = int'(N_BLOCKS);

    logic [N_BLOCKS*COORD_W-1:0] act_bx_q, act_by_q, shd_bx_q, shd_by_q, eff_bx, eff_by;
    logic [N_BLOCKS*SIZE_W-1:0]  act_bw_q, act_bh_q, shd_bw_q, shd_bh_q, eff_bw, eff_bh;
    logic [COORD_W-1:0]          act_sx_q, act_sy_q, shd_sx_q, shd_sy_q, eff_sx, eff_sy;
    logic [SIZE_W-1:0]           act_ss_q, shd_ss_q, eff_ss;
    logic                        busy_q, swap, accept;

    // Origin + size is formed one bit wider so large blocks near the edge never wrap.
    function automatic logic in_span(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] o,
                                     input logic [SIZE_W-1:0] s);
        logic [COORD_W:0] lim;
        lim = {1'b0, o} + EXT_W'(s);
        return (p >= o) && ({1'b0, p} < lim);
    endfunction

    assign swap   = FRAME_START & busy_q;
    assign accept = GEOM_LOAD & ~busy_q;

    // A pixel arriving with FRAME_START already sees the geometry being applied.
    assign eff_bx = swap ? shd_bx_q : act_bx_q;
    assign eff_by = swap ? shd_by_q : act_by_q;
    assign eff_bw = swap ? shd_bw_q : act_bw_q;
    assign eff_bh = swap ? shd_bh_q : act_bh_q;
    assign eff_sx = swap ? shd_sx_q : act_sx_q;
    assign eff_sy = swap ? shd_sy_q : act_sy_q;
    assign eff_ss = swap ? shd_ss_q : act_ss_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            act_bx_q <= '0; act_by_q <= '0; act_bw_q <= '0; act_bh_q <= '0;
            act_sx_q <= '0; act_sy_q <= '0; act_ss_q <= '0;
            shd_bx_q <= '0; shd_by_q <= '0; shd_bw_q <= '0; shd_bh_q <= '0;
            shd_sx_q <= '0; shd_sy_q <= '0; shd_ss_q <= '0;
            busy_q   <= 1'b0;
        end else if (swap) begin
            act_bx_q <= shd_bx_q; act_by_q <= shd_by_q; act_bw_q <= shd_bw_q;
            act_bh_q <= shd_bh_q; act_sx_q <= shd_sx_q; act_sy_q <= shd_sy_q;
            act_ss_q <= shd_ss_q;
            busy_q   <= 1'b0;
        end else if (accept) begin
            shd_bx_q <= BLOCK_X; shd_by_q <= BLOCK_Y; shd_bw_q <= BLOCK_W;
            shd_bh_q <= BLOCK_H; shd_sx_q <= SQUARE_X; shd_sy_q <= SQUARE_Y;
            shd_ss_q <= SQUARE_SIZE;
            busy_q   <= 1'b1;
        end
    end

    logic [N_BLOCKS-1:0] blk_hit;
    logic                sq_hit;

    always_comb begin
        blk_hit = '0;
        for (int i = 0; i < NB; i++) begin
            blk_hit[i] = in_span(X, eff_bx[(NB-1-i)*COORD_W +: COORD_W],
                                 eff_bw[(NB-1-i)*SIZE_W +: SIZE_W]) &&
                         in_span(Y, eff_by[(NB-1-i)*COORD_W +: COORD_W],
                                 eff_bh[(NB-1-i)*SIZE_W +: SIZE_W]);
        end
        sq_hit = in_span(X, eff_sx, eff_ss) && in_span(Y, eff_sy, eff_ss);
    end

    logic                s1_valid_q, s1_sq_q;
    logic [N_BLOCKS-1:0] s1_blk_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid_q <= 1'b0;
            s1_blk_q   <= '0;
            s1_sq_q    <= 1'b0;
        end else begin
            s1_valid_q <= PIX_VALID;
            s1_blk_q   <= blk_hit;
            s1_sq_q    <= sq_hit;
        end
    end

    logic [N_BLOCKS-1:0] in_block_d, in_block_q;
    logic [IDX_W-1:0]    hit_index_d, hit_index_q;
    logic                in_square_d, in_square_q, is_empty_d, is_empty_q, out_valid_q;

    always_comb begin
        in_block_d  = '0;
        hit_index_d = '0;
        for (int i = NB - 1; i >= 0; i--) begin
            in_block_d[NB-1-i] = s1_valid_q & s1_blk_q[i];
            if (s1_valid_q && s1_blk_q[i]) begin
                hit_index_d = IDX_W'(i);
            end
        end
        in_square_d = s1_valid_q & s1_sq_q;
        is_empty_d  = s1_valid_q & ~(|s1_blk_q) & ~s1_sq_q;
    end

    // The stage-1 pixel at FRAME_START is folded into the closing frame, and marked so it
    // is not counted again once it reaches stage 2.
    logic [N_BLOCKS-1:0] acc_q, acc_d, s1_contrib, s2_contrib, frame_mask, mask_q;
    logic                s2_old_q, done_q, collide_q;

    always_comb begin
        s1_contrib = in_block_d & {N_BLOCKS{in_square_d}};
        s2_contrib = s2_old_q ? '0 : (in_block_q & {N_BLOCKS{in_square_q}});
        frame_mask = acc_q | s2_contrib | s1_contrib;
        acc_d      = FRAME_START ? '0 : (acc_q | s2_contrib);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            in_block_q  <= '0;
            in_square_q <= 1'b0;
            is_empty_q  <= 1'b0;
            hit_index_q <= '0;
            acc_q       <= '0;
            s2_old_q    <= 1'b0;
            done_q      <= 1'b0;
            mask_q      <= '0;
            collide_q   <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q;
            in_block_q  <= in_block_d;
            in_square_q <= in_square_d;
            is_empty_q  <= is_empty_d;
            hit_index_q <= hit_index_d;
            acc_q       <= acc_d;
            s2_old_q    <= FRAME_START;
            done_q      <= FRAME_START;
            if (FRAME_START) begin
                mask_q    <= frame_mask;
                collide_q <= |frame_mask;
            end
        end
    end

    assign GEOM_BUSY    = busy_q;
    assign OUT_VALID    = out_valid_q;
    assign IN_BLOCK     = in_block_q;
    assign IN_SQUARE    = in_square_q;
    assign IS_EMPTY     = is_empty_q;
    assign HIT_INDEX    = hit_index_q;
    assign FRAME_DONE   = done_q;
    assign COLLIDE      = collide_q;
    assign COLLIDE_MASK = mask_q;

endmodule

// File: tb/tb_position_judge_pipe.sv
// Bench for position_judge_pipe: directed scenarios plus randomized traffic, all checked
// against a frame-level behavioural model.
module tb_position_judge_pipe;
    localparam int N = 4;

    logic       CLK = 1'b0;
    logic       RST_N, FRAME_START, PIX_VALID, GEOM_LOAD;
    logic [9:0] X, Y, SQUARE_X, SQUARE_Y;
    logic [7:0] SQUARE_SIZE;
    logic [9:0] gbx[N], gby[N];
    logic [7:0] gbw[N], gbh[N];
    logic [39:0] blk_x, blk_y;
    logic [31:0] blk_w, blk_h;
    logic       GEOM_BUSY, OUT_VALID, IN_SQUARE, IS_EMPTY, FRAME_DONE, COLLIDE;
    logic [3:0] IN_BLOCK, COLLIDE_MASK;
    logic [1:0] HIT_INDEX;

    always #5 CLK = ~CLK;

    always_comb begin
        blk_x = '0; blk_y = '0; blk_w = '0; blk_h = '0;
        for (int b = 0; b < N; b++) begin
            blk_x[(N-1-b)*10 +: 10] = gbx[b];
            blk_y[(N-1-b)*10 +: 10] = gby[b];
            blk_w[(N-1-b)*8 +: 8]   = gbw[b];
            blk_h[(N-1-b)*8 +: 8]   = gbh[b];
        end
    end

    position_judge_pipe #(.N_BLOCKS(4), .COORD_W(10), .SIZE_W(8), .IDX_W(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .FRAME_START(FRAME_START), .PIX_VALID(PIX_VALID),
        .X(X), .Y(Y), .BLOCK_X(blk_x), .BLOCK_Y(blk_y), .BLOCK_W(blk_w), .BLOCK_H(blk_h),
        .SQUARE_X(SQUARE_X), .SQUARE_Y(SQUARE_Y), .SQUARE_SIZE(SQUARE_SIZE),
        .GEOM_LOAD(GEOM_LOAD), .GEOM_BUSY(GEOM_BUSY), .OUT_VALID(OUT_VALID),
        .IN_BLOCK(IN_BLOCK), .IN_SQUARE(IN_SQUARE), .IS_EMPTY(IS_EMPTY),
        .HIT_INDEX(HIT_INDEX), .FRAME_DONE(FRAME_DONE), .COLLIDE(COLLIDE),
        .COLLIDE_MASK(COLLIDE_MASK)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: geometry as plain integers, frame mask gathered per pixel at
    // the cycle it is presented.
    int act_x[N], act_y[N], act_w[N], act_h[N], shd_x[N], shd_y[N], shd_w[N], shd_h[N];
    int act_sx, act_sy, act_ss, shd_sx, shd_sy, shd_ss;
    bit m_busy;
    logic [3:0] frame_acc, m_mask;
    logic m_done;
    logic [8:0] d1, exp_pix;
    logic [6:0] exp_st;

    function automatic bit inside_rect(int px, int py, int ox, int oy, int w, int h);
        return (px >= ox) && (px < ox + w) && (py >= oy) && (py < oy + h);
    endfunction

    task automatic model_edge();
        logic [3:0] hb;
        logic       sq;
        int         hi;
        if (!RST_N) begin
            for (int b = 0; b < N; b++) begin
                act_x[b] = 0; act_y[b] = 0; act_w[b] = 0; act_h[b] = 0;
                shd_x[b] = 0; shd_y[b] = 0; shd_w[b] = 0; shd_h[b] = 0;
            end
            act_sx = 0; act_sy = 0; act_ss = 0; shd_sx = 0; shd_sy = 0; shd_ss = 0;
            m_busy = 0; frame_acc = '0; m_mask = '0; m_done = 0; d1 = '0; exp_pix = '0;
        end else begin
            if (FRAME_START && m_busy) begin
                act_x = shd_x; act_y = shd_y; act_w = shd_w; act_h = shd_h;
                act_sx = shd_sx; act_sy = shd_sy; act_ss = shd_ss;
            end
            hb = '0; sq = 1'b0; hi = 0;
            if (PIX_VALID) begin
                sq = inside_rect(int'(X), int'(Y), act_sx, act_sy, act_ss, act_ss);
                for (int b = N - 1; b >= 0; b--) begin
                    if (inside_rect(int'(X), int'(Y), act_x[b], act_y[b], act_w[b], act_h[b])) begin
                        hb[N-1-b] = 1'b1;
                        hi = b;
                    end
                end
            end
            m_done = FRAME_START;
            if (FRAME_START) begin
                m_mask = frame_acc;
                frame_acc = '0;
            end
            if (sq) frame_acc = frame_acc | hb;
            if (FRAME_START && m_busy) begin
                m_busy = 0;
            end else if (GEOM_LOAD && !m_busy) begin
                for (int b = 0; b < N; b++) begin
                    shd_x[b] = int'(gbx[b]); shd_y[b] = int'(gby[b]);
                    shd_w[b] = int'(gbw[b]); shd_h[b] = int'(gbh[b]);
                end
                shd_sx = int'(SQUARE_X); shd_sy = int'(SQUARE_Y); shd_ss = int'(SQUARE_SIZE);
                m_busy = 1;
            end
            exp_pix = d1;
            d1 = {PIX_VALID, hb, sq, PIX_VALID && (hb == 4'b0) && !sq, 2'(hi)};
        end
        exp_st = {m_done, |m_mask, m_mask, m_busy};
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle();
        PIX_VALID = 0; FRAME_START = 0; GEOM_LOAD = 0;
    endtask

    task automatic pix(input int px, input int py);
        PIX_VALID = 1; X = 10'(px); Y = 10'(py);
    endtask

    task automatic set_block(input int b, input int bx, input int by, input int bw, input int bh);
        gbx[b] = 10'(bx); gby[b] = 10'(by); gbw[b] = 8'(bw); gbh[b] = 8'(bh);
    endtask

    task automatic test_reset();
        RST_N = 0; FRAME_START = 1; PIX_VALID = 1; GEOM_LOAD = 1; X = 5; Y = 5;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if ({OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE, COLLIDE,
                 COLLIDE_MASK, GEOM_BUSY} !== 16'h0)
                $display("FAIL reset_outputs: got %h want 0000",
                         {OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE,
                          COLLIDE, COLLIDE_MASK, GEOM_BUSY});
            else n_pass++;
        end
        RST_N = 1; idle();
        tick();
    endtask

    task automatic test_empty();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) pix(5, 5); else idle();
            tick();
            n_checks++;
            if ({OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX} !== exp_pix)
                $display("FAIL empty_pix: got %b want %b",
                         {OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX}, exp_pix);
            else n_pass++;
            if (k == 1) begin
                n_checks++;
                if ({OUT_VALID, IS_EMPTY, IN_BLOCK} !== 6'b110000)
                    $display("FAIL empty_const: got %b want 110000", {OUT_VALID, IS_EMPTY, IN_BLOCK});
                else n_pass++;
            end
        end
    endtask

    task automatic test_edges();
        int   xs[4] = '{99, 100, 119, 120};
        logic [3:0] seq;
        seq = '0;
        set_block(0, 100, 50, 20, 10);
        for (int k = 0; k < 8; k++) begin
            idle();
            if (k == 0) GEOM_LOAD = 1;
            else if (k == 1) FRAME_START = 1;
            else if (k < 6) pix(xs[k-2], 50);
            tick();
            if (k >= 3 && k <= 6) seq[6-k] = IN_BLOCK[3];
            n_checks++;
            if ({OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE, COLLIDE,
                 COLLIDE_MASK, GEOM_BUSY} !== {exp_pix, exp_st})
                $display("FAIL edges_step%0d: got %b want %b", k,
                         {OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE,
                          COLLIDE, COLLIDE_MASK, GEOM_BUSY}, {exp_pix, exp_st});
            else n_pass++;
        end
        n_checks++;
        if ({seq, HIT_INDEX} !== 6'b011000)
            $display("FAIL edges_seq: got %b want 011000", {seq, HIT_INDEX});
        else n_pass++;
    endtask

    task automatic test_multi_hit();
        set_block(1, 190, 195, 20, 10);
        set_block(2, 200, 200, 1, 1);
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k == 0) GEOM_LOAD = 1;
            else if (k == 1) FRAME_START = 1;
            else if (k == 2) pix(200, 200);
            tick();
            n_checks++;
            if ({OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE, COLLIDE,
                 COLLIDE_MASK, GEOM_BUSY} !== {exp_pix, exp_st})
                $display("FAIL multi_step%0d: got %b want %b", k,
                         {OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE,
                          COLLIDE, COLLIDE_MASK, GEOM_BUSY}, {exp_pix, exp_st});
            else n_pass++;
            if (k == 3) begin
                n_checks++;
                if ({IN_BLOCK, HIT_INDEX, IS_EMPTY} !== 7'b0110010)
                    $display("FAIL multi_const: got %b want 0110010", {IN_BLOCK, HIT_INDEX, IS_EMPTY});
                else n_pass++;
            end
        end
    endtask

    task automatic test_geom_swap();
        for (int k = 0; k < 10; k++) begin
            idle();
            if (k == 0) begin set_block(0, 300, 50, 20, 10); GEOM_LOAD = 1; pix(100, 50); end
            else if (k == 1) begin set_block(0, 500, 50, 20, 10); GEOM_LOAD = 1; pix(105, 50); end
            else if (k == 2) pix(300, 50);
            else if (k == 4) FRAME_START = 1;
            else if (k == 6) pix(300, 50);
            else if (k == 7) pix(100, 50);
            tick();
            n_checks++;
            if ({OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE, COLLIDE,
                 COLLIDE_MASK, GEOM_BUSY} !== {exp_pix, exp_st})
                $display("FAIL swap_step%0d: got %b want %b", k,
                         {OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE,
                          COLLIDE, COLLIDE_MASK, GEOM_BUSY}, {exp_pix, exp_st});
            else n_pass++;
            if (k == 3 || k == 5) begin
                n_checks++;
                if (GEOM_BUSY !== (k == 3))
                    $display("FAIL swap_busy%0d: got %b want %b", k, GEOM_BUSY, k == 3);
                else n_pass++;
            end
        end
    endtask

    task automatic test_collide();
        set_block(0, 100, 50, 20, 10);
        SQUARE_X = 100; SQUARE_Y = 50; SQUARE_SIZE = 8;
        for (int k = 0; k < 10; k++) begin
            idle();
            if (k == 0) GEOM_LOAD = 1;
            else if (k == 1 || k == 6 || k == 8) FRAME_START = 1;
            else if (k < 6) pix(100 + k, 52);
            tick();
            n_checks++;
            if ({OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE, COLLIDE,
                 COLLIDE_MASK, GEOM_BUSY} !== {exp_pix, exp_st})
                $display("FAIL collide_step%0d: got %b want %b", k,
                         {OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE,
                          COLLIDE, COLLIDE_MASK, GEOM_BUSY}, {exp_pix, exp_st});
            else n_pass++;
            if (k == 6 || k == 8) begin
                n_checks++;
                if ({FRAME_DONE, COLLIDE, COLLIDE_MASK} !== ((k == 6) ? 6'b111000 : 6'b100000))
                    $display("FAIL collide_frame%0d: got %b want %b", k,
                             {FRAME_DONE, COLLIDE, COLLIDE_MASK},
                             (k == 6) ? 6'b111000 : 6'b100000);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 8; k++) begin
            idle();
            RST_N = 1;
            if (k == 0) begin GEOM_LOAD = 1; pix(101, 51); end
            else if (k < 3) pix(102, 51);
            else if (k == 3) begin RST_N = 0; FRAME_START = 1; end
            else if (k == 5) FRAME_START = 1;
            tick();
            n_checks++;
            if ({OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE, COLLIDE,
                 COLLIDE_MASK, GEOM_BUSY} !== {exp_pix, exp_st})
                $display("FAIL rstmid_step%0d: got %b want %b", k,
                         {OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE,
                          COLLIDE, COLLIDE_MASK, GEOM_BUSY}, {exp_pix, exp_st});
            else n_pass++;
            if (k == 3 || k == 5) begin
                n_checks++;
                if ({FRAME_DONE, COLLIDE, COLLIDE_MASK, GEOM_BUSY} !== ((k == 5) ? 7'b1000000 : 7'b0))
                    $display("FAIL rstmid_const%0d: got %b want %b", k,
                             {FRAME_DONE, COLLIDE, COLLIDE_MASK, GEOM_BUSY},
                             (k == 5) ? 7'b1000000 : 7'b0);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        bit prev_fs;
        prev_fs = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0)
                    set_block(b, $urandom_range(960, 1023), $urandom_range(0, 60),
                              $urandom_range(200, 255), $urandom_range(0, 30));
                else
                    set_block(b, $urandom_range(0, 60), $urandom_range(0, 60),
                              $urandom_range(0, 30), $urandom_range(0, 30));
            end
            SQUARE_X = 10'($urandom_range(0, 60));
            SQUARE_Y = 10'($urandom_range(0, 60));
            SQUARE_SIZE = 8'($urandom_range(0, 30));
            RST_N = ($urandom_range(0, 299) != 0);
            FRAME_START = prev_fs ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            prev_fs = FRAME_START;
            GEOM_LOAD = ($urandom_range(0, 9) == 0);
            PIX_VALID = ($urandom_range(0, 9) < 7);
            X = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(990, 1023))
                                            : 10'($urandom_range(0, 79));
            Y = 10'($urandom_range(0, 79));
            tick();
            n_checks++;
            if ({OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE, COLLIDE,
                 COLLIDE_MASK, GEOM_BUSY} !== {exp_pix, exp_st})
                $display("FAIL random_cycle%0d: got %b want %b", k,
                         {OUT_VALID, IN_BLOCK, IN_SQUARE, IS_EMPTY, HIT_INDEX, FRAME_DONE,
                          COLLIDE, COLLIDE_MASK, GEOM_BUSY}, {exp_pix, exp_st});
            else n_pass++;
        end
        RST_N = 1; idle();
    endtask

    initial begin
        RST_N = 0; idle(); X = 0; Y = 0;
        SQUARE_X = 0; SQUARE_Y = 0; SQUARE_SIZE = 0;
        for (int b = 0; b < N; b++) set_block(b, 0, 0, 0, 0);
        test_reset();
        test_empty();
        test_edges();
        test_multi_hit();
        test_geom_swap();
        test_collide();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
